// File: rtl/dmem_pkg.sv
// dmem_pkg: state encoding and sizing helpers shared by the banked data memory.
package dmem_pkg;

   typedef enum logic {
      DMEM_IDLE  = 1'b0,
      DMEM_SPLIT = 1'b1
   } dmem_state_e;

   // Number of byte lanes in one storage row.
   function automatic int dmem_nb(input int data_w);
      return data_w / 8;
   endfunction

   // Width of the byte offset inside a row.
   function automatic int dmem_off_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   // Width of the row index for a given capacity.
   function automatic int dmem_row_w(input int depth_bytes, input int data_w);
      return $clog2(depth_bytes / (data_w / 8));
   endfunction

endpackage

// File: rtl/dmem_row_ram.sv
// dmem_row_ram: single-port row RAM with per-lane write enables and a
// registered read port. Contents are deliberately never reset.
module dmem_row_ram
   import dmem_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ROWS   = 8192,
   parameter int ROW_W  = 13
) (
   input  logic                clk,
   input  logic                en,
   input  logic [DATA_W/8-1:0] wen,
   input  logic [ROW_W-1:0]    addr,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata
);

   localparam int NB = dmem_nb(DATA_W);

   logic [DATA_W-1:0] mem [ROWS];

   // One access per cycle: enabled lanes are written, the row is read into the output register.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < NB; i++) begin
            if (wen[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_banked_rw.sv
// dmem_banked_rw: byte-addressed, little-endian data memory with a
// request/response handshake and configurable read latency.
// Define DMEM_MISALIGN_SPLIT_EN to split misaligned accesses into two row
// beats; without it misaligned requests are answered with rsp_err.
module dmem_banked_rw
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 15,
   parameter int DEPTH_BYTES = 16384,
   parameter int RD_LAT      = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err
);

   localparam int NB    = dmem_nb(DATA_W);
   localparam int OFF_W = dmem_off_w(DATA_W);
   localparam int ROWS  = DEPTH_BYTES / NB;
   localparam int ROW_W = dmem_row_w(DEPTH_BYTES, DATA_W);

   logic              accept;
   logic              misaligned;
   logic [ROW_W-1:0]  req_row;
   logic [OFF_W-1:0]  req_off;

   logic              ram_en;
   logic [NB-1:0]     ram_wen;
   logic [ROW_W-1:0]  ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic              s1_valid;
   logic              s1_err;
   logic              s1_read;
   logic [DATA_W-1:0] s1_rdata;

   // Wrap the byte address into the array and split it into row and lane offset.
   always_comb begin
      req_row    = ROW_W'((32'(req_addr) % DEPTH_BYTES) / NB);
      req_off    = req_addr[OFF_W-1:0];
      misaligned = (req_off != '0);
   end

   assign accept = req_valid && req_ready;

`ifdef DMEM_MISALIGN_SPLIT_EN
   dmem_state_e       state_q;
   dmem_state_e       state_d;
   logic [ROW_W-1:0]  req_row_next;
   logic [2*DATA_W-1:0] wdata_wide;
   logic [2*NB-1:0]   be_wide;
   logic              split_we;
   logic [ROW_W-1:0]  split_row;
   logic [OFF_W-1:0]  split_off;
   logic [DATA_W-1:0] split_wdata;
   logic [NB-1:0]     split_be;
   logic              s1_split;
   logic [OFF_W-1:0]  s1_off;
   logic [DATA_W-1:0] hold_q;

   // Shift request lanes by the offset: low half feeds beat 1, high half feeds beat 2.
   always_comb begin
      req_row_next = (req_row == ROW_W'(ROWS - 1)) ? '0 : req_row + ROW_W'(1);
      wdata_wide   = {{DATA_W{1'b0}}, req_wdata} << {req_off, 3'b000};
      be_wide      = {{NB{1'b0}}, req_be} << req_off;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= DMEM_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and ready: a misaligned accept costs one extra SPLIT cycle.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      case (state_q)
         DMEM_IDLE: begin
            req_ready = rst_n;
            if (rst_n && req_valid && misaligned) begin
               state_d = DMEM_SPLIT;
            end
         end
         DMEM_SPLIT: begin
            state_d = DMEM_IDLE;
         end
         default: begin
            state_d = DMEM_IDLE;
         end
      endcase
   end

   // Remember what the second beat needs at acceptance time.
   always_ff @(posedge clk) begin
      if (accept) begin
         split_we    <= req_we;
         split_row   <= req_row_next;
         split_off   <= req_off;
         split_wdata <= wdata_wide[2*DATA_W-1:DATA_W];
         split_be    <= be_wide[2*NB-1:NB];
      end
   end

   // RAM port: second beat in SPLIT, otherwise the incoming request; reset blocks beat 2.
   always_comb begin
      ram_en    = 1'b0;
      ram_addr  = req_row;
      ram_wdata = wdata_wide[DATA_W-1:0];
      ram_wen   = '0;
      if (state_q == DMEM_SPLIT) begin
         ram_en    = rst_n;
         ram_addr  = split_row;
         ram_wdata = split_wdata;
         ram_wen   = (split_we && rst_n) ? split_be : '0;
      end else if (accept) begin
         ram_en  = 1'b1;
         ram_wen = req_we ? be_wide[NB-1:0] : '0;
      end
   end

   // First response stage: aligned requests respond now, split ones after beat 2.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
         s1_read  <= 1'b0;
         s1_split <= 1'b0;
         s1_off   <= '0;
      end else if (state_q == DMEM_SPLIT) begin
         s1_valid <= 1'b1;
         s1_err   <= 1'b0;
         s1_read  <= !split_we;
         s1_split <= 1'b1;
         s1_off   <= split_off;
      end else begin
         s1_valid <= accept && !misaligned;
         s1_err   <= 1'b0;
         s1_read  <= accept && !req_we && !misaligned;
         s1_split <= 1'b0;
         s1_off   <= '0;
      end
   end

   // Keep the beat-1 row while beat 2 is being read.
   always_ff @(posedge clk) begin
      if (state_q == DMEM_SPLIT) begin
         hold_q <= ram_rdata;
      end
   end

   // Stitch the two rows back into request byte order; writes answer zero.
   always_comb begin
      s1_rdata = '0;
      if (s1_read) begin
         s1_rdata = s1_split ? DATA_W'({ram_rdata, hold_q} >> {s1_off, 3'b000}) : ram_rdata;
      end
   end
`else
   assign req_ready = rst_n;

   // RAM port: misaligned requests never touch storage.
   always_comb begin
      ram_en    = accept;
      ram_addr  = req_row;
      ram_wdata = req_wdata;
      ram_wen   = (accept && req_we && !misaligned) ? req_be : '0;
   end

   // First response stage: misaligned requests come back as errors.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
         s1_read  <= 1'b0;
      end else begin
         s1_valid <= accept;
         s1_err   <= accept && misaligned;
         s1_read  <= accept && !req_we && !misaligned;
      end
   end

   // Only successful reads return data.
   always_comb begin
      s1_rdata = s1_read ? ram_rdata : '0;
   end
`endif

   dmem_row_ram #(
      .DATA_W (DATA_W),
      .ROWS   (ROWS),
      .ROW_W  (ROW_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .wen   (ram_wen),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   generate
      if (RD_LAT == 1) begin : g_lat1
         assign rsp_valid = s1_valid;
         assign rsp_err   = s1_err;
         assign rsp_rdata = s1_rdata;
      end else begin : g_latn
         logic [RD_LAT-2:0] vld_q;
         logic [RD_LAT-2:0] err_q;
         logic [DATA_W-1:0] dat_q [RD_LAT-1];

         // Extra latency stages, flushed by reset.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               vld_q <= '0;
               err_q <= '0;
               for (int i = 0; i < RD_LAT - 1; i++) begin
                  dat_q[i] <= '0;
               end
            end else begin
               vld_q[0] <= s1_valid;
               err_q[0] <= s1_err;
               dat_q[0] <= s1_rdata;
               for (int i = 1; i < RD_LAT - 1; i++) begin
                  vld_q[i] <= vld_q[i-1];
                  err_q[i] <= err_q[i-1];
                  dat_q[i] <= dat_q[i-1];
               end
            end
         end

         assign rsp_valid = vld_q[RD_LAT-2];
         assign rsp_err   = err_q[RD_LAT-2];
         assign rsp_rdata = dat_q[RD_LAT-2];
      end
   endgenerate

endmodule

// File: doc/dmem_banked_rw.md
# dmem_banked_rw

Parametrised single-port data memory with request/response handshake, per-byte write enables, configurable read latency and optional misaligned-access splitting. Storage is one word-wide row array; a request addresses bytes and is little-endian (byte at `req_addr` is `rdata[7:0]`). Sits between the load/store stage and data storage, replacing the fixed 16-bit/16 kB data memory in new cores.

## Interface
- `DATA_W`, 16: word width in bits; power of two, ≥16. `NB = DATA_W/8` byte lanes.
- `ADDR_W`, 15: byte-address width.
- `DEPTH_BYTES`, 16384: capacity in bytes; multiple of `NB`. `ROWS = DEPTH_BYTES/NB`.
- `RD_LAT`, 1: response latency in cycles, 1..4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: write data, lane i → byte `req_addr+i`.
- `req_be` in NB: byte enables, writes only; ignored on reads.
- `rsp_valid` out 1: one-cycle response pulse, one per accepted request; no backpressure.
- `rsp_rdata` out DATA_W: read data; 0 for writes and errors.
- `rsp_err` out 1: request rejected (misaligned, split disabled).

## Operation
- Byte address wraps modulo `DEPTH_BYTES`; row index wraps modulo `ROWS`.
- Aligned (`addr % NB == 0`): one row access; write updates lanes with `be=1` only.
- Every accepted request, read or write, yields exactly one response, in acceptance order.
- FSM: IDLE, SPLIT. IDLE: `req_ready=1`. Misaligned accept with split enabled → SPLIT for one cycle (`req_ready=0`), then IDLE.
- Split, offset o: beat 1 = row r, lanes o..NB-1 ← request bytes 0..NB-1-o; beat 2 = row r+1, lanes 0..o-1 ← bytes NB-o..NB-1. Request fields registered at acceptance. Read data assembled from both beats.
- Read in cycle after a write to same bytes returns new data (no stale read).
- Storage not reset; contents preserved across reset.
- Reset: FSM→IDLE, latency pipeline cleared, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `req_ready=0` while `rst_n=0`, 1 in first cycle after release. Reset during SPLIT drops the pending beat and its response; beat-1 write already committed stays.

## Timing
- Aligned: request accepted at edge N → `rsp_valid` high in the cycle after edge N+RD_LAT-1 (RD_LAT=1: cycle right after acceptance).
- Split: response one cycle later than aligned (RD_LAT+1); next request accepted at edge N+2.
- Throughput: one aligned request per cycle, back-to-back.
- Error response: same latency as aligned, no memory change.

## Configuration
- `DMEM_MISALIGN_SPLIT_EN` defined: misaligned requests split as above, `rsp_err=0`.
- Undefined: SPLIT state absent, `req_ready` tied to 1 out of reset; misaligned request accepted, memory untouched, response at RD_LAT with `rsp_err=1`, `rsp_rdata=0`.

## Structure
- Package `dmem_pkg`: FSM state enum (`DMEM_IDLE`, `DMEM_SPLIT`), helper functions for `NB`, offset width `$clog2(NB)`, row index width.
- Sub-module `dmem_row_ram`: `ROWS`×`DATA_W` single-port RAM, per-lane write enable, registered read (1 cycle); extra RD_LAT-1 stages in the parent.

## Test plan
- DATA_W=16, RD_LAT=1: write 0xBEEF @0x0010 be=11, read @0x0010 → 0xBEEF one cycle after acceptance; byte @0x0010 = 0xEF.
- Write 0x1234 @0x0020 be=01 over 0xFFFF → read 0xFF34.
- Split on, DATA_W=32: write 0xAABBCCDD @0x0003, read @0x0003 → 0xAABBCCDD at RD_LAT+1, `req_ready` low one cycle; read @0x0004 → 0x??AABBCC lanes[23:0] = 0xAABBCC.
- Split off: read @0x0001 → `rsp_err=1`, `rsp_rdata=0`, memory unchanged.
- Wrap: write @DEPTH_BYTES-1 (split on, 16-bit) 0x5566 → byte DEPTH_BYTES-1=0x66, byte 0=0x55.
- RD_LAT=3, 8 back-to-back reads → 8 in-order pulses starting 3 cycles after first accept; `rst_n` low mid-split → no response, outputs 0.
